// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline control blocks.
package riscv_pipe_pkg;

  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned REG_AW       = $clog2(NUM_REGS_DEF);

  // One in-flight instruction downstream of ID.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } shadow_entry_t;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_match.sv
// Compares one ID source register against the checked shadow entries.
// Reports a hit plus the youngest (lowest-index) matching entry.
module hazard_match
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned SW = 2
) (
  input  shadow_entry_t [N-1:0] entries,
  input  logic [REG_AW-1:0]     rs,
  input  logic                  rs_used,
  input  logic                  id_valid,
  output logic                  hit_c,
  output logic [SW-1:0]         idx_c,
  output logic                  is_load_c
);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit_c     = 1'b0;
    idx_c     = '0;
    is_load_c = 1'b0;
    if (id_valid && rs_used && (rs != REG_AW'(REG_ZERO))) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        if (entries[k].valid && (entries[k].rd == rs)) begin
          hit_c     = 1'b1;
          idx_c     = SW'(k);
          is_load_c = entries[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Interlock and flush controller: shadow pipeline of post-ID destinations,
// RAW stall generation, redirect squash and stall/flush perf counters.
// Optional forwarding selection is enabled by defining HAZARD_FORWARD_EN.
module pipeline_hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         id_valid,
  input  logic [$clog2(NUM_REGS)-1:0]  id_rs1,
  input  logic [$clog2(NUM_REGS)-1:0]  id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [$clog2(NUM_REGS)-1:0]  id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_is_load,
  input  logic                         redirect,
  input  logic                         perf_clear,
  output logic                         stall,
  output logic                         flush_id,
  output logic                         bubble_ex,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs1,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs2,
  output logic [CNT_W-1:0]             stall_count,
  output logic [CNT_W-1:0]             flush_count
);

  localparam int unsigned SW   = $clog2(DEPTH + 1);
  // With WB bypass the WB entry's write is already visible to ID.
  localparam int unsigned NCHK = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  shadow_entry_t [DEPTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]          stall_count_q, stall_count_d;
  logic [CNT_W-1:0]          flush_count_q, flush_count_d;

  logic [REG_AW-1:0] rs1_x, rs2_x, rd_x;
  logic              hit1_c, hit2_c, ld1_c, ld2_c;
  logic [SW-1:0]     idx1_c, idx2_c;
  logic              haz1_c, haz2_c;

  assign rs1_x = REG_AW'(id_rs1);
  assign rs2_x = REG_AW'(id_rs2);
  assign rd_x  = REG_AW'(id_rd);

  hazard_match #(.N(NCHK), .SW(SW)) u_match_rs1 (
    .entries   (shadow_q[NCHK-1:0]),
    .rs        (rs1_x),
    .rs_used   (id_rs1_used),
    .id_valid  (id_valid),
    .hit_c     (hit1_c),
    .idx_c     (idx1_c),
    .is_load_c (ld1_c)
  );

  hazard_match #(.N(NCHK), .SW(SW)) u_match_rs2 (
    .entries   (shadow_q[NCHK-1:0]),
    .rs        (rs2_x),
    .rs_used   (id_rs2_used),
    .id_valid  (id_valid),
    .hit_c     (hit2_c),
    .idx_c     (idx2_c),
    .is_load_c (ld2_c)
  );

`ifdef HAZARD_FORWARD_EN
  // Forwarding: only a load still in EX cannot be bypassed.
  always_comb begin
    haz1_c      = hit1_c && (idx1_c == '0) && ld1_c;
    haz2_c      = hit2_c && (idx2_c == '0) && ld2_c;
    fwd_sel_rs1 = hit1_c ? (idx1_c + SW'(1)) : '0;
    fwd_sel_rs2 = hit2_c ? (idx2_c + SW'(1)) : '0;
  end
`else
  logic unused_fwd_c;
  assign unused_fwd_c = ^{idx1_c, idx2_c, ld1_c, ld2_c};

  // Full interlock: any match in the checked range stalls.
  always_comb begin
    haz1_c      = hit1_c;
    haz2_c      = hit2_c;
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
  end
`endif

  // The WB entry is only shifted out when it is excluded from checks.
  logic unused_wb_c;
  assign unused_wb_c = ^shadow_q[DEPTH-1];

  // Control outputs; a redirect overrides any hazard.
  always_comb begin
    stall     = (haz1_c | haz2_c) & ~redirect;
    flush_id  = redirect;
    bubble_ex = stall | redirect;
  end

  // Shadow pipeline shift; stalled or squashed ID instructions enter as bubbles.
  always_comb begin
    shadow_d            = shadow_q;
    shadow_d[0].valid   = id_valid & id_reg_write & (rd_x != REG_AW'(REG_ZERO))
                          & ~stall & ~redirect;
    shadow_d[0].rd      = rd_x;
    shadow_d[0].is_load = id_is_load;
    for (int k = 1; k < int'(DEPTH); k++) begin
      shadow_d[k] = shadow_q[k-1];
    end
  end

  // Perf counters; clear wins over increment, natural wrap.
  always_comb begin
    stall_count_d = perf_clear ? '0 : stall_count_q + CNT_W'(stall);
    flush_count_d = perf_clear ? '0 : flush_count_q + CNT_W'(flush_id);
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q      <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      shadow_q      <= shadow_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Parametrised interlock and flush controller for the pipelined RISC-V core. It tracks the destination register of every instruction in flight downstream of ID in a DEPTH-entry shadow pipeline, and stalls IF/ID on read-after-write hazards. It squashes the ID instruction on a control-flow redirect and keeps stall and flush performance counters. It sits beside the IF_ID/ID_EX registers and drives their hold/flush inputs and the PC hold.

Parameters:
DEPTH, 3, number of stages after ID (EX, MEM, WB); range 2..6
NUM_REGS, 32, architectural register count; register 0 is hard-wired zero
WB_BYPASS, 1, 1 = register file write in WB is visible to an ID read in the same cycle, so the WB entry is excluded from hazard checks
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_rs1  input  $clog2(NUM_REGS)  ID source 1 address
id_rs2  input  $clog2(NUM_REGS)  ID source 2 address
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd  input  $clog2(NUM_REGS)  ID destination address
id_reg_write  input  1  instruction writes rd
id_is_load  input  1  instruction is a load
redirect  input  1  taken branch or jump resolved this cycle
perf_clear  input  1  synchronous clear of both counters
stall  output  1  hold PC and IF_ID this cycle
flush_id  output  1  squash IF_ID contents
bubble_ex  output  1  load a NOP into ID_EX
fwd_sel_rs1  output  $clog2(DEPTH+1)  forwarding source for rs1 (FWD_EN only; otherwise tied to 0)
fwd_sel_rs2  output  $clog2(DEPTH+1)  forwarding source for rs2 (same)
stall_count  output  CNT_W  cycles with stall=1
flush_count  output  CNT_W  cycles with flush_id=1

Behaviour:
- Reset (resetn low, asynchronous): all shadow entries invalid; both counters 0. stall, flush_id, bubble_ex, fwd_sel_* are 0.
- Shadow entry k (0=EX … DEPTH-1=WB) holds {valid, rd, is_load}. Entries shift k→k+1 every cycle. The post-ID pipeline never stalls. The entry leaving WB is dropped.
- Entry 0 next value = {id_valid & id_reg_write & (id_rd!=0) & ~stall & ~redirect, id_rd, id_is_load}; otherwise invalid (bubble).
- Checked range: entries 0..DEPTH-1 if WB_BYPASS=0; entries 0..DEPTH-2 if WB_BYPASS=1.
- match_rsN = id_valid & id_rsN_used & (id_rsN!=0) & any valid checked entry with rd==id_rsN.
- hazard = match_rs1 | match_rs2. This path is purely combinational; stall responds in the same cycle.
- stall = hazard & ~redirect.
- bubble_ex = stall | redirect.
- flush_id = redirect.
- Priority: redirect overrides a hazard. No stall is raised, and the squashed instruction never enters the shadow pipeline.
- A stall persists until the producing entry leaves the checked range. With DEPTH=3, WB_BYPASS=1 and a dependent op directly behind the producer, stall is 2 cycles.
- rd=0 never creates a hazard, including for loads.
- Counters increment by 1 per qualifying cycle and wrap at 2^CNT_W.
- perf_clear has priority over increment: counter becomes 0 next cycle.
- A reset asserted mid-stall drops every in-flight entry; stall is 0 on the first cycle after release.

Optional Feature:
Macro: HAZARD_FORWARD_EN.
- Defined: fwd_sel_rsN = k+1 for the youngest valid matching checked entry k, else 0. Hazard is raised only when that youngest match is entry 0 with is_load=1 (load-use), which gives a 1-cycle stall. All other matches forward with no stall.
- Undefined: fwd_sel_* are constant 0 and the full interlock rules above apply.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - typedef shadow_entry_t {valid, rd, is_load};
  - constant REG_ZERO=0;
  - localparam helper for the register address width.
- One sub-module, hazard_match: combinational per-source comparison against the entry array, returning hit and youngest index. It is instantiated twice (rs1, rs2).

Test Plan:
- ADD x5 (rd=5) then ADD using rs1=5, FWD off, DEPTH=3, WB_BYPASS=1 -> stall=1 for exactly 2 cycles, bubble_ex=1 both cycles, stall_count=2.
- Same sequence with rd=0 -> stall never asserts, stall_count=0.
- Dependent instruction in ID with hazard and redirect=1 in the same cycle -> stall=0, flush_id=1, bubble_ex=1, entry 0 invalid next cycle, flush_count=1.
- HAZARD_FORWARD_EN, LW x7 then ADD rs2=7 -> 1-cycle stall, then fwd_sel_rs2=2 (MEM). With ADD producer instead of LW -> no stall, fwd_sel_rs2=1.
- Assert resetn low during a 2-cycle stall -> outputs 0 immediately; after release, re-issued ID instruction with rs1=5 shows stall=0.
- Hold stall high 5 cycles, pulse perf_clear on cycle 3 together with stall -> stall_count reads 0 after cycle 3, then 2 after cycle 5.
